// File: rtl/uart_alu_bridge_if.sv
// uart_alu_bridge_if
// Groups the byte-stream and ALU signals around uart_alu_bridge.
//   i_rx_data/i_rx_done   : byte and one-cycle strobe from the UART receiver
//   i_tx_done             : one-cycle strobe when the transmitter finishes a byte
//   i_alu_data/carry/zero : combinational ALU result and flags
//   o_alu_data_a/b/op     : registered operands and opcode towards the ALU
//   o_tx_data/o_tx_start  : byte and one-cycle request towards the transmitter
//   o_busy/o_frame_err    : status (busy while executing/sending, timeout pulse)
// slave  : the bridge side
// master : the surrounding UART/ALU side
interface uart_alu_bridge_if #(
    parameter int NB_DATA      = 16,
    parameter int NB_OPERATION = 6
);
    logic [7:0]              i_rx_data;
    logic                    i_rx_done;
    logic                    i_tx_done;
    logic [NB_DATA-1:0]      i_alu_data;
    logic                    i_alu_carry;
    logic                    i_alu_zero;
    logic [NB_DATA-1:0]      o_alu_data_a;
    logic [NB_DATA-1:0]      o_alu_data_b;
    logic [NB_OPERATION-1:0] o_alu_data_op;
    logic [7:0]              o_tx_data;
    logic                    o_tx_start;
    logic                    o_busy;
    logic                    o_frame_err;

    modport slave (
        input  i_rx_data, i_rx_done, i_tx_done, i_alu_data, i_alu_carry, i_alu_zero,
        output o_alu_data_a, o_alu_data_b, o_alu_data_op, o_tx_data, o_tx_start,
               o_busy, o_frame_err
    );

    modport master (
        output i_rx_data, i_rx_done, i_tx_done, i_alu_data, i_alu_carry, i_alu_zero,
        input  o_alu_data_a, o_alu_data_b, o_alu_data_op, o_tx_data, o_tx_start,
               o_busy, o_frame_err
    );
endinterface

// File: rtl/uart_alu_bridge.sv
// uart_alu_bridge
// Collects a frame {A (N_BYTES, LSB first), B (N_BYTES, LSB first), opcode}
// from the UART receiver, hands it to the ALU, then streams the result (and
// optionally a flags byte) back out through the UART transmitter.
// Ports:
//   i_clk : clock
//   i_rst : synchronous reset, active low
//   bus   : uart_alu_bridge_if.slave (rx/tx handshakes, ALU operands/result, status)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RX_A     | collecting operand A bytes (idle when cnt == 0)
// RX_B     | collecting operand B bytes
// RX_OP    | waiting for the opcode byte
// EXEC     | one cycle: capture ALU result and flags
// TX_BYTE  | one cycle: request transmission of byte cnt
// TX_WAIT  | waiting for the transmitter to finish byte cnt
module uart_alu_bridge #(
    parameter int NB_DATA        = 16,
    parameter int NB_OPERATION   = 6,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int SEND_FLAGS     = 0
) (
    input logic              i_clk,
    input logic              i_rst,
    uart_alu_bridge_if.slave bus
);
    localparam int N_BYTES = NB_DATA / 8;
    localparam int N_TX    = N_BYTES + ((SEND_FLAGS != 0) ? 1 : 0);
    localparam int CW      = $clog2(N_BYTES + 1);
    localparam int TW      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [CW-1:0] CNT_LAST_RX = CW'(N_BYTES - 1);
    localparam logic [CW-1:0] CNT_LAST_TX = CW'(N_TX - 1);
    localparam logic [CW-1:0] CNT_FLAGS   = CW'(N_BYTES);
    localparam logic [TW-1:0] IDLE_LOAD   = TW'(TIMEOUT_CYCLES);

    localparam logic [2:0] S_RX_A    = 3'd0;
    localparam logic [2:0] S_RX_B    = 3'd1;
    localparam logic [2:0] S_RX_OP   = 3'd2;
    localparam logic [2:0] S_EXEC    = 3'd3;
    localparam logic [2:0] S_TX_BYTE = 3'd4;
    localparam logic [2:0] S_TX_WAIT = 3'd5;

    logic [2:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           idle_q, idle_d;
    logic [NB_DATA-1:0]      a_q, a_d;
    logic [NB_DATA-1:0]      b_q, b_d;
    logic [NB_OPERATION-1:0] op_q, op_d;
    logic [NB_DATA-1:0]      result_q, result_d;
    logic [7:0]              flags_q, flags_d;
    logic                    frame_err_q, frame_err_d;

    logic rx_state;
    logic rx_partial;
    logic timeout_hit;
    logic [7:0] tx_byte;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        result_d    = result_q;
        flags_d     = flags_q;
        frame_err_d = 1'b0;

        rx_state   = (state_q == S_RX_A) || (state_q == S_RX_B) || (state_q == S_RX_OP);
        rx_partial = ((state_q == S_RX_A) && (cnt_q != '0)) ||
                     (state_q == S_RX_B) || (state_q == S_RX_OP);
        // A byte arriving in the expiry cycle takes priority over the abort.
        timeout_hit = (TIMEOUT_CYCLES != 0) && rx_partial && !bus.i_rx_done && (idle_q == '0);

        // Idle down-counter: reloaded by each accepted byte, expires at zero.
        if (rx_state && bus.i_rx_done) begin
            idle_d = IDLE_LOAD;
        end else if (rx_partial && (idle_q != '0)) begin
            idle_d = idle_q - TW'(1);
        end

        if (timeout_hit) begin
            state_d     = S_RX_A;
            cnt_d       = '0;
            frame_err_d = 1'b1;
        end else begin
            case (state_q)
                S_RX_A: begin
                    if (bus.i_rx_done) begin
                        a_d[{cnt_q, 3'b000} +: 8] = bus.i_rx_data;
                        if (cnt_q == CNT_LAST_RX) begin
                            cnt_d   = '0;
                            state_d = S_RX_B;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                S_RX_B: begin
                    if (bus.i_rx_done) begin
                        b_d[{cnt_q, 3'b000} +: 8] = bus.i_rx_data;
                        if (cnt_q == CNT_LAST_RX) begin
                            cnt_d   = '0;
                            state_d = S_RX_OP;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                S_RX_OP: begin
                    if (bus.i_rx_done) begin
                        op_d    = bus.i_rx_data[NB_OPERATION-1:0];
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    result_d = bus.i_alu_data;
                    flags_d  = {6'b0, bus.i_alu_zero, bus.i_alu_carry};
                    cnt_d    = '0;
                    state_d  = S_TX_BYTE;
                end
                S_TX_BYTE: begin
                    state_d = S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (bus.i_tx_done) begin
                        if (cnt_q == CNT_LAST_TX) begin
                            cnt_d   = '0;
                            state_d = S_RX_A;
                        end else begin
                            cnt_d   = cnt_q + CW'(1);
                            state_d = S_TX_BYTE;
                        end
                    end
                end
                default: begin
                    state_d = S_RX_A;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // cnt == N_BYTES only occurs when the flags byte is being sent.
    always_comb begin
        if (cnt_q == CNT_FLAGS) begin
            tx_byte = flags_q;
        end else begin
            tx_byte = result_q[{cnt_q, 3'b000} +: 8];
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= S_RX_A;
            cnt_q       <= '0;
            idle_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            result_q    <= '0;
            flags_q     <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.o_alu_data_a  = a_q;
    assign bus.o_alu_data_b  = b_q;
    assign bus.o_alu_data_op = op_q;
    assign bus.o_tx_data     = tx_byte;
    assign bus.o_tx_start    = (state_q == S_TX_BYTE);
    assign bus.o_busy        = (state_q == S_EXEC) || (state_q == S_TX_BYTE) ||
                               (state_q == S_TX_WAIT);
    assign bus.o_frame_err   = frame_err_q;
endmodule

// File: tb/tb_uart_alu_bridge.sv
// tb_uart_alu_bridge
// Four bridge instances sharing one clock and reset:
//   0: NB_DATA=16, TIMEOUT=50, no flags
//   1: NB_DATA=16, TIMEOUT=50, flags byte
//   2: NB_DATA=8,  default timeout, no flags
//   3: NB_DATA=32, timeout disabled, no flags
// The ALU beside each instance adds A and B; carry/zero come from bench variables.
module tb_uart_alu_bridge;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] rx_data   [4];
    logic       rx_done   [4];
    logic       tx_done   [4];
    logic       alu_carry [4];
    logic       alu_zero  [4];

    logic [31:0] o_a     [4];
    logic [31:0] o_b     [4];
    logic [7:0]  o_op    [4];
    logic [7:0]  o_txd   [4];
    logic        o_start [4];
    logic        o_busy  [4];
    logic        o_ferr  [4];

    int n_checks = 0;
    int n_err    = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int NBD = (g == 2) ? 8 : ((g == 3) ? 32 : 16);
        localparam int TO  = (g == 2) ? 1000000 : ((g == 3) ? 0 : 50);
        localparam int SF  = (g == 1) ? 1 : 0;

        uart_alu_bridge_if #(.NB_DATA(NBD), .NB_OPERATION(6)) ifc ();

        assign ifc.i_rx_data   = rx_data[g];
        assign ifc.i_rx_done   = rx_done[g];
        assign ifc.i_tx_done   = tx_done[g];
        assign ifc.i_alu_carry = alu_carry[g];
        assign ifc.i_alu_zero  = alu_zero[g];
        assign ifc.i_alu_data  = ifc.o_alu_data_a + ifc.o_alu_data_b;

        assign o_a[g]     = 32'(ifc.o_alu_data_a);
        assign o_b[g]     = 32'(ifc.o_alu_data_b);
        assign o_op[g]    = 8'(ifc.o_alu_data_op);
        assign o_txd[g]   = ifc.o_tx_data;
        assign o_start[g] = ifc.o_tx_start;
        assign o_busy[g]  = ifc.o_busy;
        assign o_ferr[g]  = ifc.o_frame_err;

        uart_alu_bridge #(
            .NB_DATA(NBD), .NB_OPERATION(6), .TIMEOUT_CYCLES(TO), .SEND_FLAGS(SF)
        ) u_dut (
            .i_clk (clk),
            .i_rst (rst_n),
            .bus   (ifc.slave)
        );
    end

    typedef struct {
        int          k;
        int          nb;
        int          ntx;
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  opb;
        logic [7:0]  exp_op;
        logic [31:0] exp_res;
        logic [7:0]  exp_flags;
        logic        carry;
        logic        zero;
        bit          inject;
    } vec_t;

    vec_t vecs [10];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic send_byte(input int k, input logic [7:0] b);
        rx_data[k] = b;
        rx_done[k] = 1'b1;
        tick();
        rx_done[k] = 1'b0;
    endtask

    task automatic send_frame(input int k, input int nb, input logic [31:0] a,
                              input logic [31:0] b, input logic [7:0] opb);
        logic [31:0] sh;
        for (int i = 0; i < nb; i++) begin
            sh = a >> (8 * i);
            send_byte(k, sh[7:0]);
        end
        for (int i = 0; i < nb; i++) begin
            sh = b >> (8 * i);
            send_byte(k, sh[7:0]);
        end
        send_byte(k, opb);
    endtask

    // Entered in the cycle after the opcode strobe; returns in the cycle after the last tx_done.
    task automatic finish_frame(input int k, input int nb, input int ntx,
                                input logic [31:0] ea, input logic [31:0] eb,
                                input logic [7:0] eop, input logic [31:0] eres,
                                input logic [7:0] efl, input bit inj);
        logic [31:0] sh;
        logic [7:0]  eb8;
        chk("exec_busy",  32'(o_busy[k]), 32'd1);
        chk("exec_start", 32'(o_start[k]), 32'd0);
        chk("operand_a",  o_a[k], ea);
        chk("operand_b",  o_b[k], eb);
        chk("opcode",     32'(o_op[k]), 32'(eop));
        if (inj) begin
            rx_data[k] = 8'hAA;
            rx_done[k] = 1'b1;
        end
        tick();
        rx_done[k] = 1'b0;
        for (int i = 0; i < ntx; i++) begin
            sh  = eres >> (8 * i);
            eb8 = (i == nb) ? efl : sh[7:0];
            chk("tx_start", 32'(o_start[k]), 32'd1);
            chk("tx_data",  32'(o_txd[k]), 32'(eb8));
            chk("tx_busy",  32'(o_busy[k]), 32'd1);
            if (inj) begin
                rx_data[k] = 8'hAA;
                rx_done[k] = 1'b1;
            end
            tick();
            rx_done[k] = 1'b0;
            chk("tx_start_single", 32'(o_start[k]), 32'd0);
            tx_done[k] = 1'b1;
            if (inj) begin
                rx_data[k] = 8'hAA;
                rx_done[k] = 1'b1;
            end
            tick();
            tx_done[k] = 1'b0;
            rx_done[k] = 1'b0;
        end
        chk("done_busy",  32'(o_busy[k]), 32'd0);
        chk("done_start", 32'(o_start[k]), 32'd0);
        chk("keep_a",     o_a[k], ea);
        chk("keep_op",    32'(o_op[k]), 32'(eop));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end (limit 500000 ns)");
        $fatal(1);
    end

    initial begin
        int pulses;
        int first;

        //            k nb ntx  a             b             opb    op     res           fl     c     z     inj
        vecs[0] = '{0, 2, 2, 32'h1234,     32'h0F0F,     8'h20, 8'h20, 32'h2143,     8'h00, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{0, 2, 2, 32'hFFFF,     32'h0002,     8'hE0, 8'h20, 32'h0001,     8'h00, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{0, 2, 2, 32'h00FF,     32'h0001,     8'h3F, 8'h3F, 32'h0100,     8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{0, 2, 2, 32'h8000,     32'h8000,     8'hC1, 8'h01, 32'h0000,     8'h00, 1'b1, 1'b1, 1'b1};
        vecs[4] = '{1, 2, 3, 32'h1234,     32'h0F0F,     8'h20, 8'h20, 32'h2143,     8'h01, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{1, 2, 3, 32'hFFFF,     32'h0001,     8'h20, 8'h20, 32'h0000,     8'h03, 1'b1, 1'b1, 1'b1};
        vecs[6] = '{2, 1, 1, 32'h12,       32'h0F,       8'h20, 8'h20, 32'h21,       8'h00, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{2, 1, 1, 32'hF0,       32'h20,       8'h7F, 8'h3F, 32'h10,       8'h00, 1'b1, 1'b0, 1'b1};
        vecs[8] = '{3, 4, 4, 32'hDEAD0000, 32'h0000BEEF, 8'h20, 8'h20, 32'hDEADBEEF, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{3, 4, 4, 32'h12345678, 32'h11111111, 8'h05, 8'h05, 32'h23456789, 8'h00, 1'b0, 1'b0, 1'b0};

        for (int k = 0; k < 4; k++) begin
            rx_data[k]   = 8'h00;
            rx_done[k]   = 1'b0;
            tx_done[k]   = 1'b0;
            alu_carry[k] = 1'b1;
            alu_zero[k]  = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) tick();

        chk("rst_a",     o_a[0], 32'h0);
        chk("rst_b",     o_b[0], 32'h0);
        chk("rst_op",    32'(o_op[0]), 32'h0);
        chk("rst_txd",   32'(o_txd[0]), 32'h0);
        chk("rst_start", 32'(o_start[0]), 32'h0);
        chk("rst_busy",  32'(o_busy[0]), 32'h0);
        chk("rst_ferr",  32'(o_ferr[0]), 32'h0);
        rst_n = 1'b1;
        tick();

        // Partial frame then silence: exactly one error pulse, 51 cycles after the strobe cycle.
        send_byte(0, 8'h34);
        send_byte(0, 8'h12);
        send_byte(0, 8'h0F);
        pulses = 0;
        first  = -1;
        for (int j = 0; j < 60; j++) begin
            if (o_ferr[0]) begin
                pulses++;
                if (first < 0) first = j;
            end
            tick();
        end
        chk("tmo_pulses", 32'(pulses), 32'd1);
        chk("tmo_cycle",  32'(first), 32'd51);
        chk("tmo_keep_a", o_a[0], 32'h1234);
        chk("tmo_keep_b", o_b[0], 32'h000F);
        chk("tmo_busy",   32'(o_busy[0]), 32'd0);
        send_frame(0, 2, 32'h0001, 32'h0002, 8'h20);
        finish_frame(0, 2, 2, 32'h0001, 32'h0002, 8'h20, 32'h0003, 8'h00, 1'b0);

        // Byte arriving in the exact expiry cycle wins over the timeout.
        send_byte(0, 8'h34);
        repeat (50) tick();
        send_byte(0, 8'h12);
        chk("tmo_byte_wins", 32'(o_ferr[0]), 32'd0);
        send_byte(0, 8'h0F);
        send_byte(0, 8'h0F);
        send_byte(0, 8'h20);
        finish_frame(0, 2, 2, 32'h1234, 32'h0F0F, 8'h20, 32'h2143, 8'h00, 1'b0);

        for (int v = 0; v < 10; v++) begin
            alu_carry[vecs[v].k] = vecs[v].carry;
            alu_zero[vecs[v].k]  = vecs[v].zero;
            send_frame(vecs[v].k, vecs[v].nb, vecs[v].a, vecs[v].b, vecs[v].opb);
            finish_frame(vecs[v].k, vecs[v].nb, vecs[v].ntx, vecs[v].a, vecs[v].b,
                         vecs[v].exp_op, vecs[v].exp_res, vecs[v].exp_flags, vecs[v].inject);
        end

        // Reset while waiting for the transmitter.
        send_frame(0, 2, 32'h1234, 32'h0F0F, 8'h20);
        tick();
        chk("pre_rst_start", 32'(o_start[0]), 32'd1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("midrst_a",     o_a[0], 32'h0);
        chk("midrst_b",     o_b[0], 32'h0);
        chk("midrst_op",    32'(o_op[0]), 32'h0);
        chk("midrst_txd",   32'(o_txd[0]), 32'h0);
        chk("midrst_start", 32'(o_start[0]), 32'h0);
        chk("midrst_busy",  32'(o_busy[0]), 32'h0);
        chk("midrst_ferr",  32'(o_ferr[0]), 32'h0);
        pulses = 0;
        for (int j = 0; j < 20; j++) begin
            tx_done[0] = (j == 4);
            if (o_start[0]) pulses++;
            tick();
        end
        tx_done[0] = 1'b0;
        chk("midrst_no_start", 32'(pulses), 32'd0);
        alu_carry[0] = 1'b1;
        alu_zero[0]  = 1'b0;
        send_frame(0, 2, 32'h0001, 32'h0002, 8'h20);
        finish_frame(0, 2, 2, 32'h0001, 32'h0002, 8'h20, 32'h0003, 8'h00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/uart_alu_bridge.md
# uart_alu_bridge

Parametrised successor of the UART-to-ALU interface. Assembles multi-byte operands A and B and an opcode byte from the UART receiver, presents them to the combinational ALU, and returns the result (plus an optional flags byte) to the UART transmitter. Adds byte-count generalisation, an inter-byte timeout with frame resynchronisation, and a busy indication. Sits between `uart_rx`/`uart_tx` and `alu` in the top level.

## Interface
- `NB_DATA`, 16, operand/result width in bits; multiple of 8, ≥ 8. `N_BYTES = NB_DATA/8`.
- `NB_OPERATION`, 6, opcode width; ≤ 8.
- `TIMEOUT_CYCLES`, 1000000, idle clock cycles allowed between bytes of one frame; 0 disables the timeout.
- `SEND_FLAGS`, 0; when 1, a flags byte follows the result.
- `i_clk`  in  1  clock; single clock domain.
- `i_rst`  in  1  reset; synchronous, active-low.
- `i_rx_data`  in  8  received byte; valid while `i_rx_done` is high.
- `i_rx_done`  in  1  one-cycle pulse per received byte.
- `i_tx_done`  in  1  one-cycle pulse when the transmitter finishes a byte.
- `i_alu_data`  in  NB_DATA  ALU result.
- `i_alu_carry`  in  1  ALU carry flag.
- `i_alu_zero`  in  1  ALU zero flag.
- `o_alu_data_a`  out  NB_DATA  registered operand A.
- `o_alu_data_b`  out  NB_DATA  registered operand B.
- `o_alu_data_op`  out  NB_OPERATION  registered opcode.
- `o_tx_data`  out  8  byte to transmit.
- `o_tx_start`  out  1  one-cycle transmit request.
- `o_busy`  out  1  high from EXEC through the last TX_WAIT.
- `o_frame_err`  out  1  one-cycle pulse on timeout abort.

## Operation
- Frame: N_BYTES of A, N_BYTES of B, 1 opcode byte; operands little-endian (byte k → bits [8k+7:8k]).
- Opcode: low NB_OPERATION bits of the byte; upper bits ignored.
- States: RX_A, RX_B, RX_OP, EXEC, TX_BYTE, TX_WAIT. Byte counter `cnt` of width clog2(N_BYTES+1).
- RX_A / RX_B: on `i_rx_done`, write byte `cnt` of A/B directly into the output register. `cnt++`. When `cnt == N_BYTES-1`, clear `cnt` and advance to RX_B / RX_OP.
- RX_OP: on `i_rx_done`, latch the opcode and go to EXEC.
- EXEC: one cycle. Capture `i_alu_data` into the result register. Capture flags `{6'b0, i_alu_zero, i_alu_carry}`. Go to TX_BYTE with `cnt = 0`.
- TX_BYTE: one cycle. `o_tx_start = 1` and `o_tx_data` = result byte `cnt`, or the flags byte when `cnt == N_BYTES`. Go to TX_WAIT.
- TX_WAIT: on `i_tx_done`:
  - `cnt++`.
  - If more bytes remain (N_BYTES, +1 when SEND_FLAGS), go to TX_BYTE.
  - Otherwise go to RX_A with `cnt = 0`.
- `i_rx_done` in EXEC, TX_BYTE or TX_WAIT: the byte is dropped.
- Timeout:
  - An idle counter runs only while a frame is partially received (RX_A with `cnt > 0`, RX_B, RX_OP). It resets on every `i_rx_done`.
  - When it reaches TIMEOUT_CYCLES: pulse `o_frame_err`, go to RX_A with `cnt = 0`. A/B/op registers keep their partial contents.
- Simultaneous `i_rx_done` and timeout expiry: the byte wins. It is accepted, the counter resets, and there is no error.
- Simultaneous `i_rx_done` and `i_tx_done` in TX_WAIT: the tx event is processed and the rx byte is dropped.
- Reset (`i_rst == 0` at a clock edge), from any state: all registers cleared, state RX_A. Any in-progress frame or transmission is abandoned.

## Timing
- Reset values: every output 0; state RX_A; counters 0.
- Operand/opcode outputs update on the edge that samples `i_rx_done`, and are stable through EXEC and TX.
- Opcode `i_rx_done` in cycle T:
  - T+1: EXEC, `o_busy = 1`.
  - T+2: `o_tx_start = 1`, `o_tx_data` = result[7:0].
- `i_tx_done` in cycle U with bytes remaining: `o_tx_start = 1` in U+1 with the next byte.
- `o_tx_start` is never high for two consecutive cycles.
- Last `i_tx_done` in cycle U: U+1 is RX_A with `o_busy = 0`. A byte arriving at U+1 is accepted.
- Timeout: `o_frame_err` high in the cycle after the idle counter reaches TIMEOUT_CYCLES.
- Total bytes transmitted per frame: N_BYTES + SEND_FLAGS.

## Test plan
- NB_DATA=16, ALU model returns 0x2143 with carry=1, zero=0. Send 34 12 0F 0F 20 → A=0x1234, B=0x0F0F, op=0x20; tx 0x43 then 0x21; `o_tx_start` high exactly two cycles after the opcode `i_rx_done`.
- Same stimulus with SEND_FLAGS=1 → tx 0x43, 0x21, 0x01; `o_busy` falls the cycle after the third `i_tx_done`.
- TIMEOUT_CYCLES=50: send 34 12 0F, then idle 60 cycles → single `o_frame_err` pulse; state RX_A. The following full frame 01 00 02 00 20 produces a correct result.
- Bytes 0xAA injected during TX_WAIT, including in the same cycle as `i_tx_done` → dropped; next frame parses correctly.
- Reset asserted during TX_WAIT → all outputs 0 on the next cycle; no further `o_tx_start`; a new frame works.
- NB_DATA=8 and NB_DATA=32 (ALU returns 0xDEADBEEF) → 3-byte and 9-byte frames; tx EF BE AD DE for the 32-bit case.
